// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and widths for the instruction fetch unit
package fetch_pkg;
  localparam int WORD_W = 64;
  localparam int ADDR_W = 64;
  localparam int ENTRY_W = ADDR_W + WORD_W;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: flushable instruction buffer holding {pc, data} entries
module inst_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       din,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  // Empty head reads as zero so the consumer never sees stale entries
  assign dout = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential word fetcher with redirect and a small instruction buffer
module instruction_fetch import fetch_pkg::*; #(
  parameter int MEM_DEPTH  = 1025,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_enable,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_data_in,
  input  logic [WORD_W-1:0] mem_data_out,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, inflight_pc, tgt;
  logic inflight, issue, redir, go, push, pop;
  logic [CW-1:0] count;
  assign redir = redirect && state != IDLE;
  assign go    = start && state == IDLE;
  // Reserve a slot for the in-flight word so a push can never overflow
  assign issue = state == FETCH && !redir && ((count + CW'(inflight)) < CW'(FIFO_DEPTH));
  assign tgt   = redir ? redirect_pc : start_pc;
  assign push  = inflight && !redir;
  assign pop   = inst_valid && inst_ready && !redir;
  always_comb begin
    pc_n    = (redir || go) ? tgt : issue ? pc + 1'b1 : pc;
    state_n = (redir || go) ? ((tgt > LAST) ? DONE : FETCH)
            : (issue && pc == LAST) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      inflight    <= issue;
      inflight_pc <= pc;
    end
  end
  inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redir),
    .push  (push),
    .din   ({inflight_pc, mem_data_out}),
    .pop   (pop),
    .dout  ({inst_pc, inst_data}),
    .count (count)
  );
  assign inst_valid  = count != '0;
  assign mem_enable  = issue;
  assign mem_read    = 1'b1;
  assign mem_address = pc;
  assign mem_data_in = '0;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEM_DEPTH, default 1025: number of 64-bit words in the attached instruction memory; legal word addresses are 0..MEM_DEPTH-1.
REQ-002 Parameter FIFO_DEPTH, default 4: instruction buffer entries; power of two, at least 2.
REQ-003 Port clk, input, 1 bit: single clock; all logic is sampled on the posedge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: a one-cycle pulse that begins fetching at start_pc.
REQ-006 Port start_pc, input, 64 bits: first word address to fetch.
REQ-007 Port redirect, input, 1 bit: branch/jump redirect pulse.
REQ-008 Port redirect_pc, input, 64 bits: new fetch word address.
REQ-009 Port mem_enable, output, 1 bit: memory access strobe.
REQ-010 Port mem_read, output, 1 bit: memory read select; tied to 1, so this block never writes.
REQ-011 Port mem_address, output, 64 bits: memory word address.
REQ-012 Port mem_data_in, output, 64 bits: memory write data; tied to 0.
REQ-013 Port mem_data_out, input, 64 bits: memory read data; valid in the cycle after the edge that sampled mem_enable.
REQ-014 Port inst_valid, output, 1 bit: an instruction is available at the head of the buffer.
REQ-015 Port inst_ready, input, 1 bit: the consumer accepts the head instruction.
REQ-016 Port inst_data, output, 64 bits: head instruction word.
REQ-017 Port inst_pc, output, 64 bits: word address of inst_data.
REQ-018 Port busy, output, 1 bit: high when the state is not IDLE.
REQ-019 Port done, output, 1 bit: high in state DONE.

Function
REQ-020 The state machine SHALL have states IDLE, FETCH and DONE.
- IDLE to FETCH on start.
- FETCH to DONE after the request to address MEM_DEPTH-1 is issued.
- DONE to FETCH on redirect.
- Any state to IDLE on rst.
REQ-021 In FETCH, mem_enable SHALL be 1 only when occupancy + inflight < FIFO_DEPTH; mem_address = pc at that time; pc increments by 1 per issued request.
REQ-022 Memory read latency is exactly 1 cycle; the word SHALL be pushed into the buffer, with its address, on the edge after issue.
REQ-023 Handshake: a pop occurs when inst_valid and inst_ready are both 1; inst_data and inst_pc SHALL be held stable while inst_valid=1 and inst_ready=0.
REQ-024 Throughput: with inst_ready held at 1, the block SHALL deliver one instruction per cycle after a first-word latency of 2 cycles from start.
REQ-025 Full buffer: no request SHALL be issued, and no push may be lost.
REQ-026 Empty buffer: inst_valid=0; a same-cycle push and pop SHALL keep occupancy unchanged.
REQ-027 Redirect (in FETCH or DONE): flush the buffer, discard any in-flight response, set pc=redirect_pc, and enter FETCH with the first issue on the next cycle.
REQ-028 A redirect SHALL override a same-cycle pop; inst_valid=0 on the following cycle.
REQ-029 start outside IDLE and redirect in IDLE SHALL be ignored.
REQ-030 start_pc or redirect_pc >= MEM_DEPTH SHALL go directly to DONE with no request issued.
REQ-031 In DONE, buffered instructions SHALL continue to drain normally.

Reset
REQ-032 On rst: state=IDLE, pc=0, buffer empty, inflight=0; mem_enable=0, mem_address=0, inst_valid=0, inst_data=0, inst_pc=0, busy=0, done=0.
REQ-033 rst asserted mid-fetch SHALL discard the in-flight response; nothing SHALL be pushed on the cycle after reset is released.

Structure
REQ-034 A shared package fetch_pkg SHALL hold the state encoding (IDLE=0, FETCH=1, DONE=2), WORD_W=64 and ADDR_W=64.
REQ-035 The buffer SHALL be sub-module inst_fifo: 128-bit entries ({pc, data}), synchronous flush input, count output.

Verification
REQ-036 Reset, then start with start_pc=0, memory words 0..7 preloaded with 0x100+i, inst_ready=1 -> inst_pc 0,1,2,... with data 0x100,0x101,... one per cycle; first inst_valid 2 cycles after start.
REQ-037 inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 requests are issued, mem_enable stays 0 afterwards, and inst_data stays stable.
REQ-038 redirect with redirect_pc=5 on the cycle inst_pc=2 is being popped -> next valid instruction has inst_pc=5; words 2-4 are never delivered.
REQ-039 start with start_pc=1022, MEM_DEPTH=1025 -> addresses 1022,1023,1024 are issued, done=1, and all three words drain.
REQ-040 rst asserted the cycle after an issue -> all outputs are at reset values and no push follows.
REQ-041 start with start_pc=2000 -> done=1 on the next cycle, and mem_enable is never asserted.
